// File: rtl/move_stack.sv
`default_nettype none
// ============================================================================
//  Module   : move_stack
//  Purpose  : Path-recording move stack for the maze solver, with reverse-move
//             output for backtracking and in-order replay of the stored path.
//  Revision : 1.0 - initial release
// ============================================================================

module move_stack #(
   parameter int DEPTH  = 256,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push_i,
   input  logic              pop_i,
   input  logic [1:0]        dir_in_i,
   output logic [1:0]        top_o,
   output logic [1:0]        back_dir_o,
   output logic [ADDR_W:0]   count_o,
   output logic              empty_o,
   output logic              full_o,
   output logic              ovf_o,
   output logic              unf_o,
   input  logic              replay_start_i,
   input  logic              replay_next_i,
   output logic [1:0]        replay_dir_o,
   output logic              replay_valid_o,
   output logic              replay_done_o,
   output logic              busy_o
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_REPLAY = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   localparam logic [ADDR_W:0] c_full_cnt = (ADDR_W+1)'(DEPTH);

   state_t              state_q, state_d;
   logic [ADDR_W:0]     sp_q, sp_d;
   logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic                ovf_q, ovf_d;
   logic                unf_q, unf_d;
   logic [1:0]          mem_q [DEPTH];

   logic                w_idle;
   logic                w_empty;
   logic                w_full;
   logic [ADDR_W:0]     w_sp_m1;
   logic [ADDR_W-1:0]   w_top_idx;
   logic [1:0]          w_top_entry;
   logic [1:0]          w_rd_entry;
   logic                w_wr_en;
   logic [ADDR_W-1:0]   w_wr_addr;

   assign w_idle      = (state_q == ST_IDLE);
   assign w_empty     = (sp_q == '0);
   assign w_full      = (sp_q == c_full_cnt);
   assign w_sp_m1     = sp_q - 1'b1;
   assign w_top_idx   = w_sp_m1[ADDR_W-1:0];
   assign w_top_entry = mem_q[w_top_idx];
   assign w_rd_entry  = mem_q[rd_ptr_q];

   assign top_o       = w_empty ? 2'b00 : w_top_entry;
   assign back_dir_o  = w_empty ? 2'b00 : ~w_top_entry;
   assign count_o     = sp_q;
   assign empty_o     = w_empty;
   assign full_o      = w_full;
   assign ovf_o       = ovf_q;
   assign unf_o       = unf_q;

   // Stack pointer and error flags; stack operations are frozen while busy.
   always_comb begin
      sp_d      = sp_q;
      ovf_d     = ovf_q;
      unf_d     = unf_q;
      w_wr_en   = 1'b0;
      w_wr_addr = sp_q[ADDR_W-1:0];
      if (w_idle) begin
         if (push_i && pop_i && !w_empty) begin
            w_wr_en   = 1'b1;
            w_wr_addr = w_top_idx;
         end else if (push_i) begin
            if (w_full) begin
               ovf_d = 1'b1;
            end else begin
               w_wr_en   = 1'b1;
               w_wr_addr = sp_q[ADDR_W-1:0];
               sp_d      = sp_q + 1'b1;
            end
         end else if (pop_i) begin
            if (w_empty) begin
               unf_d = 1'b1;
            end else begin
               sp_d = w_sp_m1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         mem_q[w_wr_addr] <= dir_in_i;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         sp_q     <= '0;
         rd_ptr_q <= '0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         sp_q     <= sp_d;
         rd_ptr_q <= rd_ptr_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
      end
   end

   // Replay walks the array bottom-up; the last accept is at rd_ptr == sp-1.
   always_comb begin
      state_d        = state_q;
      rd_ptr_d       = rd_ptr_q;
      replay_valid_o = 1'b0;
      replay_dir_o   = 2'b00;
      replay_done_o  = 1'b0;
      busy_o         = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (replay_start_i) begin
               if (!w_empty) begin
                  state_d  = ST_REPLAY;
                  rd_ptr_d = '0;
               end else begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_REPLAY: begin
            busy_o         = 1'b1;
            replay_valid_o = 1'b1;
            replay_dir_o   = w_rd_entry;
            if (replay_next_i) begin
               if ({1'b0, rd_ptr_q} == w_sp_m1) begin
                  state_d = ST_DONE;
               end else begin
                  rd_ptr_d = rd_ptr_q + 1'b1;
               end
            end
         end
         ST_DONE: begin
            busy_o        = 1'b1;
            replay_done_o = 1'b1;
            state_d       = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_move_stack.sv
`default_nettype none
// ============================================================================
//  Module   : tb_move_stack
//  Purpose  : Directed self-checking bench for move_stack with a stack model
//             and a replay scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================

module tb_move_stack;

   logic        clk;
   logic        rst;
   logic        push, pop, replay_start, replay_next;
   logic [1:0]  dir_in;
   logic [1:0]  top, back_dir, replay_dir;
   logic [8:0]  count;
   logic        empty, full, ovf, unf, replay_valid, replay_done, busy;

   int          n_vec = 0;
   int          n_err = 0;

   logic [1:0]  mdl [$];
   logic [1:0]  exp_q [$];
   bit          m_ovf, m_unf, m_idle;

   move_stack #(.DEPTH(256), .ADDR_W(8)) dut (
      .clk            (clk),
      .rst            (rst),
      .push_i         (push),
      .pop_i          (pop),
      .dir_in_i       (dir_in),
      .top_o          (top),
      .back_dir_o     (back_dir),
      .count_o        (count),
      .empty_o        (empty),
      .full_o         (full),
      .ovf_o          (ovf),
      .unf_o          (unf),
      .replay_start_i (replay_start),
      .replay_next_i  (replay_next),
      .replay_dir_o   (replay_dir),
      .replay_valid_o (replay_valid),
      .replay_done_o  (replay_done),
      .busy_o         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_update(input logic p, input logic q, input logic [1:0] d);
      if (!m_idle) return;
      if (p && q && mdl.size() > 0) begin
         mdl[mdl.size()-1] = d;
      end else if (p) begin
         if (mdl.size() < 256) mdl.push_back(d);
         else m_ovf = 1'b1;
      end else if (q) begin
         if (mdl.size() > 0) void'(mdl.pop_back());
         else m_unf = 1'b1;
      end
   endtask

   task automatic do_cycle(input logic p, input logic q, input logic [1:0] d,
                           input logic s, input logic n);
      push = p; pop = q; dir_in = d; replay_start = s; replay_next = n;
      @(posedge clk);
      #1;
      push = 1'b0; pop = 1'b0; dir_in = 2'b00; replay_start = 1'b0; replay_next = 1'b0;
      model_update(p, q, d);
      if (s && m_idle) m_idle = 1'b0;
   endtask

   task automatic check_stack(input string tag);
      logic [1:0] et, eb;
      et = (mdl.size() > 0) ? mdl[mdl.size()-1] : 2'b00;
      eb = (mdl.size() > 0) ? ~mdl[mdl.size()-1] : 2'b00;
      chk({tag, ".count"}, 32'(count),    32'(mdl.size()));
      chk({tag, ".empty"}, 32'(empty),    32'(mdl.size() == 0));
      chk({tag, ".full"},  32'(full),     32'(mdl.size() == 256));
      chk({tag, ".top"},   32'(top),      32'(et));
      chk({tag, ".back"},  32'(back_dir), 32'(eb));
      chk({tag, ".ovf"},   32'(ovf),      32'(m_ovf));
      chk({tag, ".unf"},   32'(unf),      32'(m_unf));
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      #1;
      rst = 1'b0;
      mdl.delete();
      m_ovf = 1'b0; m_unf = 1'b0; m_idle = 1'b1;
   endtask

   initial begin
      logic [3:0] pat;
      int         k;
      int         guard;

      rst = 1'b0; push = 1'b0; pop = 1'b0; dir_in = 2'b00;
      replay_start = 1'b0; replay_next = 1'b0;
      m_ovf = 1'b0; m_unf = 1'b0; m_idle = 1'b1;

      // Reset state
      #2 rst = 1'b1;
      #1;
      check_stack("reset");
      chk("reset.valid", 32'(replay_valid), 32'd0);
      chk("reset.done",  32'(replay_done),  32'd0);
      chk("reset.busy",  32'(busy),         32'd0);
      rst = 1'b0;

      // Basic push / pop
      do_cycle(1, 0, 2'b01, 0, 0);
      do_cycle(1, 0, 2'b11, 0, 0);
      do_cycle(1, 0, 2'b10, 0, 0);
      check_stack("push3");
      chk("push3.top_const",  32'(top),      32'd2);
      chk("push3.back_const", 32'(back_dir), 32'd1);
      do_cycle(0, 1, 2'b00, 0, 0);
      check_stack("pop1");
      chk("pop1.top_const", 32'(top), 32'd3);

      // Drain then underflow, then asynchronous reset clears the flag
      do_cycle(0, 1, 2'b00, 0, 0);
      do_cycle(0, 1, 2'b00, 0, 0);
      do_cycle(0, 1, 2'b00, 0, 0);
      check_stack("underflow");
      chk("underflow.unf_const", 32'(unf), 32'd1);
      rst = 1'b1;
      #1;
      chk("async_rst.unf",   32'(unf),   32'd0);
      chk("async_rst.count", 32'(count), 32'd0);
      rst = 1'b0;
      mdl.delete(); m_ovf = 1'b0; m_unf = 1'b0; m_idle = 1'b1;

      // Fill to DEPTH then overflow
      for (int i = 0; i < 256; i++) begin
         do_cycle(1, 0, (i % 2 == 1) ? 2'b11 : 2'b00, 0, 0);
      end
      check_stack("fill");
      chk("fill.count_const", 32'(count), 32'd256);
      do_cycle(1, 0, 2'b00, 0, 0);
      check_stack("overflow");
      chk("overflow.top_const", 32'(top), 32'd3);
      chk("overflow.ovf_const", 32'(ovf), 32'd1);

      // Simultaneous push and pop replaces the top
      apply_reset();
      do_cycle(1, 0, 2'b01, 0, 0);
      do_cycle(1, 0, 2'b10, 0, 0);
      do_cycle(1, 1, 2'b00, 0, 0);
      check_stack("replace");
      chk("replace.top_const", 32'(top), 32'd0);
      apply_reset();
      do_cycle(1, 1, 2'b11, 0, 0);
      check_stack("replace_empty");
      chk("replace_empty.count_const", 32'(count), 32'd1);

      // Replay with a hold cycle, three accepts and a push while busy
      apply_reset();
      do_cycle(1, 0, 2'b01, 0, 0);
      do_cycle(1, 0, 2'b11, 0, 0);
      do_cycle(1, 0, 2'b10, 0, 0);
      exp_q = mdl;
      do_cycle(0, 0, 2'b00, 1, 0);
      pat = 4'b1110;
      k = 0;
      guard = 0;
      while (exp_q.size() > 0 && guard < 20) begin
         chk("replay.valid", 32'(replay_valid), 32'd1);
         chk("replay.dir",   32'(replay_dir),   32'(exp_q[0]));
         chk("replay.busy",  32'(busy),         32'd1);
         chk("replay.done",  32'(replay_done),  32'd0);
         do_cycle(k == 0, 0, 2'b00, 0, pat[k % 4]);
         if (pat[k % 4]) void'(exp_q.pop_front());
         k++;
         guard++;
      end
      chk("replay.no_timeout", 32'(guard < 20), 32'd1);
      chk("replay.cycles",     32'(k),          32'd4);
      chk("replay.done_pulse", 32'(replay_done), 32'd1);
      chk("replay.valid_end",  32'(replay_valid), 32'd0);
      chk("replay.dir_end",    32'(replay_dir),   32'd0);
      do_cycle(0, 0, 2'b00, 0, 0);
      m_idle = 1'b1;
      chk("replay.done_clear", 32'(replay_done), 32'd0);
      chk("replay.busy_clear", 32'(busy),        32'd0);
      check_stack("after_replay");

      // Replay of an empty stack
      apply_reset();
      do_cycle(0, 0, 2'b00, 1, 0);
      chk("empty_replay.done",  32'(replay_done),  32'd1);
      chk("empty_replay.valid", 32'(replay_valid), 32'd0);
      chk("empty_replay.busy",  32'(busy),         32'd1);
      do_cycle(0, 0, 2'b00, 0, 0);
      m_idle = 1'b1;
      chk("empty_replay.done2",  32'(replay_done),  32'd0);
      chk("empty_replay.valid2", 32'(replay_valid), 32'd0);
      chk("empty_replay.busy2",  32'(busy),         32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
